// File: rtl/ym_pkg.sv
// Shared encodings and constants for the YM2149/AY-3-8910 bus responder.
// Mode/state encodings match the raw {bdir,bc1} strobe pair.
package ym_pkg;

    typedef enum logic [1:0] {
        MODE_IDLE  = 2'b00,
        MODE_READ  = 2'b01,
        MODE_WRITE = 2'b10,
        MODE_ADDR  = 2'b11
    } ym_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_READ  = 2'b01,
        ST_WRITE = 2'b10,
        ST_ADDR  = 2'b11
    } ym_state_e;

    localparam logic [3:0] R_MIXER     = 4'd7;
    localparam logic [3:0] R_ENV_SHAPE = 4'd13;
    localparam logic [3:0] R_IOA       = 4'd14;
    localparam logic [3:0] R_IOB       = 4'd15;

    // Implemented bits per register; unimplemented bits read back as 0
    localparam logic [7:0] REG_MASK [16] = '{
        8'hFF, 8'h0F, 8'hFF, 8'h0F,
        8'hFF, 8'h0F, 8'h1F, 8'hFF,
        8'h1F, 8'h1F, 8'h1F, 8'hFF,
        8'hFF, 8'h0F, 8'hFF, 8'hFF
    };

endpackage

// File: rtl/ym_bus_responder_if.sv
// PSG data/address bus between the Z80-side decoder and the responder.
// master drives strobes and DA; slave returns read data and drive enable.
interface ym_bus_responder_if;
    import ym_pkg::*;

    logic       bdir;
    logic       bc1;
    logic       sel;
    logic [7:0] da_in;
    logic [7:0] da_out;
    logic       da_oe;

    modport master (
        output bdir, bc1, sel, da_in,
        input  da_out, da_oe
    );

    modport slave (
        input  bdir, bc1, sel, da_in,
        output da_out, da_oe
    );

endinterface

// File: rtl/ym_bus_sync.sv
// Multi-flop synchroniser for an asynchronous bus strobe.
// Clears to 0 (idle level) on synchronous reset.
module ym_bus_sync
    import ym_pkg::*;
#(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    always_ff @(posedge clk) begin
        if (reset) ff <= '0;
        else       ff <= {ff[STAGES-2:0], d};
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/ym_bus_responder.sv
// YM2149 bus interface and 16-entry register file for one PSG instance.
// Optional I/O ports enabled by defining YM_IO_PORTS_EN.
module ym_bus_responder
    import ym_pkg::*;
#(
    parameter logic       CHIP_ID     = 1'b0,
    parameter logic [3:0] ADDR_HI     = 4'h0,
    parameter int         SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                reset,
    ym_bus_responder_if.slave   bus,
    output logic [127:0]        regs_flat,
    output logic                wr_stb,
    output logic [3:0]          wr_addr,
    output logic                env_restart
`ifdef YM_IO_PORTS_EN
    ,
    input  logic [7:0]          ioa_in,
    input  logic [7:0]          iob_in,
    output logic [7:0]          ioa_out,
    output logic [7:0]          iob_out,
    output logic                ioa_dir,
    output logic                iob_dir
`endif
);

    logic bdir_s, bc1_s, sel_s;

    ym_bus_sync #(.STAGES(SYNC_STAGES)) u_sync_bdir (
        .clk(clk), .reset(reset), .d(bus.bdir), .q(bdir_s)
    );
    ym_bus_sync #(.STAGES(SYNC_STAGES)) u_sync_bc1 (
        .clk(clk), .reset(reset), .d(bus.bc1), .q(bc1_s)
    );
    ym_bus_sync #(.STAGES(SYNC_STAGES)) u_sync_sel (
        .clk(clk), .reset(reset), .d(bus.sel), .q(sel_s)
    );

    ym_mode_e   mode;
    ym_state_e  state_q, state_d;
    logic [7:0] held_q;
    logic [3:0] addr_q;
    logic       addr_ok_q;
    logic [7:0] regs_q [16];
    logic       do_latch, do_write;
    logic [7:0] rd_data;

    assign mode = ym_mode_e'({bdir_s, bc1_s});

    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Exit actions fire in the first cycle the mode differs from the state
    always_comb begin
        state_d     = ST_IDLE;
        bus.da_oe   = 1'b0;
        bus.da_out  = 8'h00;
        unique case (mode)
            MODE_IDLE:  state_d = ST_IDLE;
            MODE_READ:  state_d = ST_READ;
            MODE_WRITE: state_d = ST_WRITE;
            MODE_ADDR:  state_d = ST_ADDR;
        endcase
        do_latch = (state_q == ST_ADDR) && (state_d != ST_ADDR);
        do_write = (state_q == ST_WRITE) && (state_d != ST_WRITE)
                   && addr_ok_q;
        if (!reset && state_d == ST_READ && addr_ok_q) begin
            bus.da_oe  = 1'b1;
            bus.da_out = rd_data;
        end
    end

    always_comb begin
        rd_data = regs_q[addr_q];
`ifdef YM_IO_PORTS_EN
        if (addr_q == R_IOA && !regs_q[R_MIXER][6]) rd_data = ioa_in;
        if (addr_q == R_IOB && !regs_q[R_MIXER][7]) rd_data = iob_in;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            held_q      <= 8'h00;
            addr_q      <= 4'h0;
            addr_ok_q   <= 1'b0;
            wr_stb      <= 1'b0;
            wr_addr     <= 4'h0;
            env_restart <= 1'b0;
            for (int i = 0; i < 16; i++) regs_q[i] <= 8'h00;
        end else begin
            wr_stb      <= do_write;
            env_restart <= do_write && (addr_q == R_ENV_SHAPE);
            if (mode != MODE_IDLE) held_q <= bus.da_in;
            if (do_latch) begin
                addr_q    <= held_q[3:0];
                addr_ok_q <= (held_q[7:4] == ADDR_HI) && (sel_s == CHIP_ID);
            end
            if (do_write) begin
                regs_q[addr_q] <= held_q & REG_MASK[addr_q];
                wr_addr        <= addr_q;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 16; i++) regs_flat[i*8 +: 8] = regs_q[i];
    end

`ifdef YM_IO_PORTS_EN
    assign ioa_out = regs_q[R_IOA];
    assign iob_out = regs_q[R_IOB];
    assign ioa_dir = regs_q[R_MIXER][6];
    assign iob_dir = regs_q[R_MIXER][7];
`endif

endmodule
